// File: rtl/vram_fetch_arbiter.sv
// Shares one VRAM read port between three scroll-layer fetchers and the sprite fetcher.
// Optional per-line grant statistics are enabled with the VRAM_ARB_STATS_EN macro.
module vram_fetch_arbiter #(
  parameter int AW      = 18,
  parameter int TIMEOUT = 63
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hbl,
  input  logic            vbl,
  input  logic [3:0]      req,
  input  logic [4*AW-1:0] req_addr,
  output logic [3:0]      req_ack,
  output logic            mem_rd,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_ack,
  output logic [1:0]      gnt_id,
  output logic            busy,
  output logic            timeout_err
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [31:0]     line_grants
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  // Abort edge is the one where the watchdog count reaches TIMEOUT.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]    gnt_id_q, gnt_id_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]    wdog_q, wdog_d;
  logic          mem_rd_q, mem_rd_d;
  logic          busy_q, busy_d;
  logic          timeout_err_q, timeout_err_d;

  logic          win_valid;
  logic [1:0]    win_id;
  logic [1:0]    rr_idx;

  always_comb begin
    win_valid = |req;
    win_id    = 2'd0;
    rr_idx    = 2'd0;
    if (hbl && !vbl) begin
      if (req[3])      win_id = 2'd3;
      else if (req[0]) win_id = 2'd0;
      else if (req[1]) win_id = 2'd1;
      else if (req[2]) win_id = 2'd2;
    end else begin
      // Walk from the farthest offset down so the nearest set bit wins last.
      for (int k = 3; k >= 0; k--) begin
        rr_idx = rr_ptr_q + 2'(k);
        if (req[rr_idx]) win_id = rr_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    gnt_id_d      = gnt_id_q;
    rr_ptr_d      = rr_ptr_q;
    wdog_d        = wdog_q;
    mem_rd_d      = mem_rd_q;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d    = WAIT;
          mem_addr_d = req_addr[int'(win_id)*AW +: AW];
          gnt_id_d   = win_id;
          mem_rd_d   = 1'b1;
          busy_d     = 1'b1;
          wdog_d     = 8'd0;
        end
      end
      WAIT: begin
        wdog_d = wdog_q + 8'd1;
        if (mem_ack) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          busy_d   = 1'b0;
          rr_ptr_d = gnt_id_q + 2'd1;
        end else if (wdog_q == WDOG_LAST) begin
          state_d       = IDLE;
          mem_rd_d      = 1'b0;
          busy_d        = 1'b0;
          timeout_err_d = 1'b1;
          rr_ptr_d      = gnt_id_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_addr_q    <= '0;
      gnt_id_q      <= 2'd0;
      rr_ptr_q      <= 2'd0;
      wdog_q        <= 8'd0;
      mem_rd_q      <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      gnt_id_q      <= gnt_id_d;
      rr_ptr_q      <= rr_ptr_d;
      wdog_q        <= wdog_d;
      mem_rd_q      <= mem_rd_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Ack is passed through in the same cycle so the requester sees data and can drop req.
  assign req_ack     = (state_q == WAIT && mem_ack) ? (4'b0001 << gnt_id_q) : 4'b0000;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign gnt_id      = gnt_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

`ifdef VRAM_ARB_STATS_EN
  logic [3:0][7:0] cnt_q, cnt_d;
  logic [31:0]     line_grants_q, line_grants_d;
  logic            hbl_prev_q;
  logic            hbl_rise;
  logic [7:0]      cnt_base;

  always_comb begin
    hbl_rise      = hbl && !hbl_prev_q;
    line_grants_d = hbl_rise ? cnt_q : line_grants_q;
    cnt_d         = cnt_q;
    cnt_base      = 8'd0;
    // An ack on the rising edge lands in the freshly cleared counter.
    for (int i = 0; i < 4; i++) begin
      cnt_base = hbl_rise ? 8'd0 : cnt_q[i];
      cnt_d[i] = (req_ack[i] && cnt_base != 8'hFF) ? cnt_base + 8'd1 : cnt_base;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      line_grants_q <= '0;
      hbl_prev_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      line_grants_q <= line_grants_d;
      hbl_prev_q    <= hbl;
    end
  end

  assign line_grants = line_grants_q;
`endif

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Directed self-checking bench for vram_fetch_arbiter; covers VRAM_ARB_STATS_EN when defined.
module tb_vram_fetch_arbiter;

  localparam int AW = 18;
  localparam int TO = 63;

  logic            clk = 1'b0;
  logic            reset;
  logic            hbl, vbl, mem_ack;
  logic [3:0]      req;
  logic [4*AW-1:0] req_addr;
  logic [3:0]      req_ack;
  logic            mem_rd, busy, timeout_err;
  logic [AW-1:0]   mem_addr;
  logic [1:0]      gnt_id;
`ifdef VRAM_ARB_STATS_EN
  logic [31:0]     line_grants;
`endif

  logic [AW-1:0] addrTab [4];
  int checks = 0;
  int passed = 0;
  int cyc = 0;

  vram_fetch_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .hbl(hbl), .vbl(vbl), .req(req), .req_addr(req_addr),
    .req_ack(req_ack), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .gnt_id(gnt_id), .busy(busy), .timeout_err(timeout_err)
`ifdef VRAM_ARB_STATS_EN
    , .line_grants(line_grants)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed still running expected finished");
    $fatal(1, "[TB] simulation time limit expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic h, input logic v, input logic a);
    req = r; hbl = h; vbl = v; mem_ack = a;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
    #1;
  endtask

  // Caller sets req during an IDLE cycle; ack arrives one cycle after mem_rd rises.
  task automatic doGrant(input string tag, input int expId, output int riseCyc);
    nextCycle();
    riseCyc = cyc;
    checkOutput({tag, " mem_rd"}, {31'd0, mem_rd}, 32'd1);
    checkOutput({tag, " gnt_id"}, {30'd0, gnt_id}, expId);
    checkOutput({tag, " mem_addr"}, {14'd0, mem_addr}, {14'd0, addrTab[expId]});
    nextCycle();
    mem_ack = 1'b1;
    #1;
    checkOutput({tag, " req_ack"}, {28'd0, req_ack}, 32'd1 << expId);
    nextCycle();
    mem_ack = 1'b0;
    #1;
    checkOutput({tag, " ack_once"}, {28'd0, req_ack}, 32'd0);
    checkOutput({tag, " rd_low"}, {31'd0, mem_rd}, 32'd0);
  endtask

  initial begin
    int r0, r1, highCnt;
    int rises [5];
    logic ackSeen;

    addrTab[0] = 18'h00AAA;
    addrTab[1] = 18'h01234;
    addrTab[2] = 18'h2BCDE;
    addrTab[3] = 18'h3F00F;
    for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = addrTab[i];

    applyReset();
    checkOutput("rst mem_rd", {31'd0, mem_rd}, 32'd0);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst mem_addr", {14'd0, mem_addr}, 32'd0);
    checkOutput("rst gnt_id", {30'd0, gnt_id}, 32'd0);
    checkOutput("rst timeout_err", {31'd0, timeout_err}, 32'd0);
    checkOutput("rst req_ack", {28'd0, req_ack}, 32'd0);

    // Single request, ack two cycles after mem_rd rises
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    checkOutput("single pre_rd", {31'd0, mem_rd}, 32'd0);
    nextCycle();
    checkOutput("single mem_rd", {31'd0, mem_rd}, 32'd1);
    checkOutput("single busy", {31'd0, busy}, 32'd1);
    checkOutput("single mem_addr", {14'd0, mem_addr}, 32'h01234);
    checkOutput("single gnt_id", {30'd0, gnt_id}, 32'd1);
    nextCycle();
    checkOutput("single no_early_ack", {28'd0, req_ack}, 32'd0);
    nextCycle();
    mem_ack = 1'b1;
    #1;
    checkOutput("single req_ack", {28'd0, req_ack}, 32'b0010);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("single ack_once", {28'd0, req_ack}, 32'd0);
    checkOutput("single rd_low", {31'd0, mem_rd}, 32'd0);
    checkOutput("single busy_low", {31'd0, busy}, 32'd0);
    applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
    doGrant("single rr_ptr2", 2, r0);

    // Round robin from rr_ptr 0 with all requests held
    applyReset();
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    doGrant("rr g0", 0, rises[0]);
    doGrant("rr g1", 1, rises[1]);
    doGrant("rr g2", 2, rises[2]);
    doGrant("rr g3", 3, rises[3]);
    doGrant("rr g4", 0, rises[4]);
    for (int i = 1; i < 5; i++) checkOutput("rr spacing", rises[i] - rises[i-1], 32'd3);

    // Horizontal blank: sprite first, then fixed 0 > 1 > 2
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
    doGrant("hbl s0", 3, r0);
    doGrant("hbl s1", 3, r0);
    applyStimulus(4'b0111, 1'b1, 1'b0, 1'b0);
    doGrant("hbl p0", 0, r0);
    applyStimulus(4'b0110, 1'b1, 1'b0, 1'b0);
    doGrant("hbl p1", 1, r0);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
    doGrant("hbl p2", 2, r0);
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0);
    doGrant("rr after_hbl", 1, r0);
    applyStimulus(4'b0101, 1'b1, 1'b1, 1'b0);
    doGrant("vbl rr", 2, r0);

    // Watchdog abort with no ack
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("wd gnt_id", {30'd0, gnt_id}, 32'd0);
    highCnt = 0;
    ackSeen = 1'b0;
    for (int k = 0; k < 200 && mem_rd; k++) begin
      highCnt++;
      if (req_ack != 4'b0000) ackSeen = 1'b1;
      nextCycle();
    end
    checkOutput("wd rd_cycles", highCnt, TO);
    checkOutput("wd busy", {31'd0, busy}, 32'd0);
    checkOutput("wd timeout_err", {31'd0, timeout_err}, 32'd1);
    checkOutput("wd no_ack", {31'd0, ackSeen}, 32'd0);
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
    doGrant("wd next", 1, r0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("wd sticky", {31'd0, timeout_err}, 32'd1);

    // Ack on the last watchdog cycle completes normally
    applyReset();
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    nextCycle();
    for (int k = 1; k < TO; k++) nextCycle();
    checkOutput("coll rd_still", {31'd0, mem_rd}, 32'd1);
    mem_ack = 1'b1;
    #1;
    checkOutput("coll req_ack", {28'd0, req_ack}, 32'b0001);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("coll timeout_err", {31'd0, timeout_err}, 32'd0);
    checkOutput("coll rd_low", {31'd0, mem_rd}, 32'd0);

    // Reset during WAIT abandons the read
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("rstw gnt_id", {30'd0, gnt_id}, 32'd2);
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("rstw mem_rd", {31'd0, mem_rd}, 32'd0);
    checkOutput("rstw busy", {31'd0, busy}, 32'd0);
    checkOutput("rstw gnt_id0", {30'd0, gnt_id}, 32'd0);
    checkOutput("rstw mem_addr", {14'd0, mem_addr}, 32'd0);
    mem_ack = 1'b1;
    #1;
    checkOutput("idle ack_ignored", {28'd0, req_ack}, 32'd0);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("idle stays", {31'd0, mem_rd}, 32'd0);
    applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
    doGrant("rstw rr_ptr0", 1, r1);

`ifdef VRAM_ARB_STATS_EN
    // Start a fresh line, then 5 sprite and 2 layer-0 grants
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) doGrant("stats spr", 3, r0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) doGrant("stats l0", 0, r0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("stats line", line_grants, 32'h05000002);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) doGrant("stats sat", 3, r0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("stats saturate", line_grants, 32'hFF000000);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vram_fetch_arbiter.md
Name: vram_fetch_arbiter

Overview:
- Shares one video RAM read port between three scroll-layer fetchers (req 0..2) and the sprite fetcher (req 3).
- Arbitration policy follows the blanking flags from the video timing generator:
  - sprite gets absolute priority during horizontal blank;
  - all other times use round-robin.
- Each grant is a single address/ack transaction. The block has a watchdog so a missing memory ack cannot stall the video pipeline.

Parameters:
- AW, 18, address width per requester and of mem_addr.
- TIMEOUT, 63, clk cycles in WAIT with no mem_ack before abort (1..255).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- hbl  in  1  horizontal blank level from video timing, same clk domain.
- vbl  in  1  vertical blank level from video timing, same clk domain.
- req  in  4  per-requester read request; bit 3 = sprite.
- req_addr  in  4*AW  packed addresses; requester i at bits [i*AW +: AW].
- req_ack  out  4  one-hot, one-cycle pulse: requester's read completed; data valid on mem_data this same cycle.
- mem_rd  out  1  read strobe to VRAM, held until mem_ack.
- mem_addr  out  AW  registered address of the granted requester.
- mem_ack  in  1  one-cycle pulse from VRAM: read done.
- gnt_id  out  2  index of the current/last granted requester.
- busy  out  1  high in WAIT.
- timeout_err  out  1  sticky: a transaction was aborted by the watchdog.

Behaviour:
- Reset values: req_ack=0, mem_rd=0, mem_addr=0, gnt_id=0, busy=0, timeout_err=0, state=IDLE, rr_ptr=0, wdog=0.
- States: IDLE, WAIT.
- IDLE, no req bit set: stay in IDLE.
- IDLE, some req bit set: select winner, then on the next edge:
  - latch mem_addr and gnt_id;
  - set mem_rd=1, busy=1, wdog=0;
  - go to WAIT.
  - Grant latency is 1 cycle: req seen at edge N gives mem_rd high after edge N.
- Winner selection, evaluated combinationally from hbl and vbl in the IDLE cycle:
  - hbl=1 and vbl=0: fixed priority 3 > 0 > 1 > 2.
  - Otherwise: round-robin over all 4. Search starts at rr_ptr and increments mod 4; the first set bit wins.
- WAIT, mem_ack=1:
  - pulse req_ack[gnt_id] for one cycle;
  - set mem_rd=0, busy=0;
  - rr_ptr = gnt_id+1 mod 4 (updated in both policy modes);
  - go to IDLE.
- WAIT, no ack: wdog increments. When wdog reaches TIMEOUT:
  - set mem_rd=0, busy=0, timeout_err=1;
  - no req_ack pulse;
  - rr_ptr advances past gnt_id so the faulty requester cannot lock the port;
  - go to IDLE.
- mem_ack in the same cycle as wdog==TIMEOUT: the ack wins; normal completion, no error.
- mem_ack while in IDLE: ignored.
- Minimum of one IDLE cycle between transactions; sustained throughput is one read per 3 cycles with a 1-cycle memory ack.
- Requester protocol:
  - hold req and req_addr until req_ack;
  - dropping req mid-WAIT does not cancel the transaction, and the ack still pulses;
  - mem_addr is not re-sampled during WAIT.
- A change in hbl/vbl during WAIT does not affect the current transaction; the policy applies at the next IDLE decision.
- Reset asserted mid-WAIT: all outputs return to reset values at that edge. Any pending VRAM read is abandoned.
- timeout_err clears only on reset.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- When defined, adds output port line_grants, 4x8 bits packed, with one saturating 8-bit counter per requester:
  - a counter increments on each req_ack pulse for that requester;
  - on the rising edge of hbl (registered compare, hbl=1 and previous hbl=0), current counts copy into line_grants and the counters clear;
  - if an ack coincides with the hbl rising edge, that ack is counted in the new line's counter;
  - reset clears all counters and line_grants.
- When undefined, the port, counters and edge detector are absent; behaviour is otherwise identical.

Test Plan:
- Single request: hbl=0, vbl=0, req=4'b0010, addr1=0x1234, mem_ack 2 cycles after mem_rd rises -> mem_rd high 1 cycle after req with mem_addr=0x1234 and gnt_id=1; req_ack=4'b0010 for exactly one cycle; then rr_ptr=2.
- Round-robin: active display, req=4'b1111 held, mem_ack 1 cycle after each mem_rd -> grant order 0,1,2,3,0; each req_ack is one cycle; 3-cycle spacing between mem_rd rises.
- Hblank priority: hbl=1, vbl=0, req=4'b1111 -> gnt_id=3 on every grant while req[3] is held. After req[3] drops -> order 0,1,2 (fixed priority).
- Watchdog: TIMEOUT=63, req=4'b0001, no mem_ack -> mem_rd drops after 63 WAIT cycles; timeout_err=1 and stays set; no req_ack. A following req=4'b0011 grants 1 first.
- Collision: mem_ack on the exact cycle wdog==TIMEOUT -> req_ack pulses and timeout_err stays 0. Separately, reset during WAIT -> mem_rd=0, busy=0, rr_ptr=0 next cycle; a later mem_ack in IDLE produces no req_ack.
- With VRAM_ARB_STATS_EN: 5 sprite grants and 2 layer-0 grants in one line, then an hbl rising edge -> line_grants[3]=5, [0]=2, others 0. 300 sprite grants in one line -> line_grants[3]=255.
